// File: rtl/neuron_fetch_pipeline.sv
// Three-stage neuron fetch pipeline (address, cache read, store) with a window counter.
// The counter flags completion of each K*K filter window one clock after its last store.
module neuron_fetch_pipeline (
   input  logic       clk,
   input  logic       layer_reset,
   input  logic [2:0] filter_width_i,
   input  logic       neuron_fetch_en_i,
   output logic       addressing_en_o,
   output logic       cache_rd_o,
   output logic       store_data_en_o,
   output logic       output_neuron_ac_en_o
);

   logic [7:0] side;
   logic [7:0] win_size;
   logic [7:0] win_last;
   logic [7:0] win_cnt_q, win_cnt_d;
   logic       ac_en_d;
   logic       addr_q, rd_q, store_q, ac_q;

   // K = 2*fw+1 never exceeds 15, so K*K (max 225) fits in 8 bits
   always_comb begin
      side     = {4'b0000, filter_width_i, 1'b1};
      win_size = side * side;
      win_last = win_size - 8'd1;
   end

   always_comb begin
      win_cnt_d = win_cnt_q;
      ac_en_d   = 1'b0;
      if (store_q) begin
         if (win_cnt_q == win_last) begin
            win_cnt_d = 8'd0;
            ac_en_d   = 1'b1;
         end else begin
            win_cnt_d = win_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge layer_reset) begin
      if (layer_reset) begin
         addr_q    <= 1'b0;
         rd_q      <= 1'b0;
         store_q   <= 1'b0;
         ac_q      <= 1'b0;
         win_cnt_q <= 8'd0;
      end else begin
         addr_q    <= neuron_fetch_en_i;
         rd_q      <= addr_q;
         store_q   <= rd_q;
         ac_q      <= ac_en_d;
         win_cnt_q <= win_cnt_d;
      end
   end

   assign addressing_en_o       = addr_q;
   assign cache_rd_o            = rd_q;
   assign store_data_en_o       = store_q;
   assign output_neuron_ac_en_o = ac_q;

endmodule

// File: tb/tb_neuron_fetch_pipeline.sv
// Scoreboard bench for neuron_fetch_pipeline: stimulus schedules expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_neuron_fetch_pipeline;

   logic       clk;
   logic       layer_reset;
   logic [2:0] filter_width;
   logic       fetch_en;
   logic       addressing_en, cache_rd, store_data_en, ac_en;

   neuron_fetch_pipeline dut (
      .clk                   (clk),
      .layer_reset           (layer_reset),
      .filter_width_i        (filter_width),
      .neuron_fetch_en_i     (fetch_en),
      .addressing_en_o       (addressing_en),
      .cache_rd_o            (cache_rd),
      .store_data_en_o       (store_data_en),
      .output_neuron_ac_en_o (ac_en)
   );

   typedef struct {
      int         tgt;
      logic [3:0] vec;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] sched[0:4];
   int         cyc;
   int         n_cmp;
   int         n_bad;
   int         stores;
   int         win;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: one comparison per scheduled cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
         exp_t e;
         logic [3:0] act;
         e   = exp_q.pop_front();
         act = {addressing_en, cache_rd, store_data_en, ac_en};
         n_cmp++;
         if (e.tgt != cyc || act !== e.vec) begin
            n_bad++;
            $display("FAIL stage_outputs cyc=%0d tgt=%0d actual={addr,rd,store,ac}=%b required=%b",
                     cyc, e.tgt, act, e.vec);
         end
      end
   end

   // Model: request n (counted from reset) is store n; a window completes on every K*K-th store
   task automatic step(input logic en);
      exp_t e;
      fetch_en = en;
      if (en) begin
         stores++;
         sched[1][3] = 1'b1;
         sched[2][2] = 1'b1;
         sched[3][1] = 1'b1;
         if (stores % win == 0) sched[4][0] = 1'b1;
      end
      e.tgt = cyc + 1;
      e.vec = sched[1];
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) sched[i] = sched[i + 1];
      sched[4] = 4'b0000;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      logic [3:0] act;
      act = {addressing_en, cache_rd, store_data_en, ac_en};
      n_cmp++;
      if (act !== 4'b0000) begin
         n_bad++;
         $display("FAIL %s actual=%b required=0000", name, act);
      end
   endtask

   // Called at posedge+1; reset lands mid-cycle, requests held high meanwhile must be ignored
   task automatic apply_reset(input logic [2:0] fw);
      #1;
      layer_reset  = 1'b1;
      fetch_en     = 1'b1;
      filter_width = fw;
      exp_q.delete();
      for (int i = 0; i <= 4; i++) sched[i] = 4'b0000;
      stores = 0;
      win    = (2 * int'(fw) + 1) * (2 * int'(fw) + 1);
      #1;
      check_zero("reset_immediate");
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_held");
      layer_reset = 1'b0;
      fetch_en    = 1'b0;
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      stores       = 0;
      win          = 1;
      layer_reset  = 1'b1;
      fetch_en     = 1'b0;
      filter_width = 3'd0;
      for (int i = 0; i <= 4; i++) sched[i] = 4'b0000;
      @(posedge clk);
      #1;

      // K=1: every store completes a window
      apply_reset(3'd0);
      repeat (21) step(1'b1);
      repeat (6) step(1'b0);

      // K=3: pulses after stores 9 and 18, residual 3 then completed by 6 more
      apply_reset(3'd1);
      repeat (21) step(1'b1);
      repeat (8) step(1'b0);
      repeat (6) step(1'b1);
      repeat (6) step(1'b0);

      // K=15: exactly one pulse after store 225, counter back at 0
      apply_reset(3'd7);
      repeat (225) step(1'b1);
      repeat (6) step(1'b0);
      repeat (224) step(1'b1);
      repeat (6) step(1'b0);
      repeat (1) step(1'b1);
      repeat (6) step(1'b0);

      // Alternating requests
      apply_reset(3'd1);
      for (int i = 0; i < 24; i++) step(i[0] == 1'b0);
      repeat (6) step(1'b0);

      // Reset two cycles into a burst, then a fresh burst
      apply_reset(3'd0);
      repeat (2) step(1'b1);
      apply_reset(3'd0);
      repeat (8) step(1'b0);
      repeat (5) step(1'b1);
      repeat (6) step(1'b0);

      // Partial window drains without a pulse, later completed
      apply_reset(3'd1);
      repeat (5) step(1'b1);
      repeat (10) step(1'b0);
      repeat (4) step(1'b1);
      repeat (6) step(1'b0);

      // Randomized traffic over several filter sizes, occasional mid-burst reset
      for (int r = 0; r < 6; r++) begin
         apply_reset(3'($urandom_range(0, 3)));
         for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
            if (r == 4 && i == 77) apply_reset(3'd2);
         end
         repeat (6) step(1'b0);
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0 pending", exp_q.size());
      end
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/neuron_fetch_pipeline.md
NEURON_FETCH_PIPELINE -- requirements
Module: neuron_fetch_pipeline

Interface
REQ-001 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: layer_reset  input  1  asynchronous, active-high reset; clears all state at the start of a layer.
REQ-004 Port: filter_width_i  input  3  filter-size code; window side K = 2*filter_width_i+1 (000->1, 001->3, ..., 111->15).
REQ-005 Port: neuron_fetch_en_i  input  1  request to fetch one input neuron this cycle.
REQ-006 Port: addressing_en_o  output  1  stage 1, address generation enable.
REQ-007 Port: cache_rd_o  output  1  stage 2, cache read strobe.
REQ-008 Port: store_data_en_o  output  1  stage 3, store fetched data into the accumulator.
REQ-009 Port: output_neuron_ac_en_o  output  1  one-cycle pulse; the output-neuron accumulation for one filter window is complete.

Function
REQ-010 All outputs SHALL be registered; no combinational input-to-output path.
REQ-011 addressing_en_o SHALL equal neuron_fetch_en_i delayed by 1 clock.
REQ-012 cache_rd_o SHALL equal addressing_en_o delayed by 1 clock (2 clocks after the request).
REQ-013 store_data_en_o SHALL equal cache_rd_o delayed by 1 clock (3 clocks after the request).
REQ-014 Each request cycle SHALL produce exactly one pulse on every stage, with no loss, merging or reordering.
REQ-015 Gaps in neuron_fetch_en_i SHALL propagate unchanged as gaps through all stages; back-to-back requests SHALL give one pulse per cycle.
REQ-016 An 8-bit window counter SHALL count store_data_en_o cycles, range 0..K*K-1 (max 224).
REQ-017 A store cycle with the counter at K*K-1 SHALL wrap the counter to 0 and assert output_neuron_ac_en_o on the next clock for exactly one cycle (4 clocks after the request of that store).
REQ-018 For K=1, output_neuron_ac_en_o SHALL pulse once per store, 1 clock after each store.
REQ-019 K*K SHALL be computed at 8-bit width (225 fits; no overflow).
REQ-020 Deasserting neuron_fetch_en_i SHALL let in-flight requests drain through all stages.
REQ-021 A partial window count SHALL be retained after draining, with no flush pulse, until completed by later stores or cleared by layer_reset.
REQ-022 filter_width_i SHALL be held stable from layer_reset deassertion to the end of the layer; behaviour when it changes mid-layer is undefined.

Reset
REQ-023 layer_reset high SHALL immediately clear all pipeline stage registers, the window counter and all outputs to 0, independent of clk.
REQ-024 neuron_fetch_en_i SHALL be ignored while layer_reset is high; the first request is accepted on the first rising edge after release.
REQ-025 Reset mid-operation SHALL discard all in-flight requests and the partial window count, with no pulse emitted afterwards.

Verification
REQ-026 filter_width_i=0, reset, then fetch_en high 21 cycles -> each of the 3 stages high 21 consecutive cycles at offsets +1/+2/+3; output_neuron_ac_en_o 21 pulses starting at +4; output count 21.
REQ-027 filter_width_i=1 (K*K=9), 21 requests -> output pulses after the 9th and 18th stores, total 2; residual window count 3.
REQ-028 filter_width_i=7 (K*K=225), 225 requests -> exactly one output pulse, 1 clock after the 225th store; the counter reads 0 afterwards.
REQ-029 Alternating fetch_en 1,0,1,0 -> identical alternating pattern on every stage at its fixed latency.
REQ-030 Assert layer_reset 2 cycles into a burst -> all outputs 0 at once, no residual pulses; next burst behaves as after a fresh reset.
REQ-031 fetch_en dropped mid-window (filter_width_i=1, 5 requests) -> 5 stores drain, no output pulse; 4 more requests -> 1 pulse.
